// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard interlock and branch-flush sequencer for the
// 5-stage RISC-V pipeline. The datapath has no forwarding, so a per-register
// scoreboard of in-flight writes holds ID until each producer reaches WB.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_id_*                    ID-stage instruction: valid, sources, dest, RegWrite
//   i_ex_branch_taken         EX resolved a taken branch this cycle
//   i_wb_valid, i_wb_rd       register-file write in WB
//   o_pc_en, o_ifid_en        front-end advance enables
//   o_ifid_flush              load NOP into IF/ID
//   o_idex_bubble             load NOP into ID/EX
//   o_issue                   ID instruction advances to EX at this edge
//   o_stall_count             saturating interlock-cycle counter
//   o_err                     sticky scoreboard overflow/underflow

// One 2-bit pending-write counter. An illegal step leaves the count
// unchanged and raises a one-cycle error pulse.
module pend_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_cnt,
  output logic       o_err
);
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    o_err = 1'b0;
    if (i_inc && !i_dec) begin
      if (cnt_q == 2'd3) o_err = 1'b1;
      else               cnt_d = cnt_q + 2'd1;
    end else if (i_dec && !i_inc) begin
      if (cnt_q == 2'd0) o_err = 1'b1;
      else               cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign o_cnt = cnt_q;
endmodule

module pipeline_ctrl #(
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_RegWrite,
  input  logic             i_ex_branch_taken,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_issue,
  output logic [CNT_W-1:0] o_stall_count,
  output logic             o_err
);
  localparam logic [2:0] FE = FLUSH_EXTRA[2:0];

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] scnt_q;
  logic             err_q;

  logic [31:0][1:0] pend;
  logic [31:0]      err_v;
  logic             hazard, flush_now, stall_now, issue;

  // x0 is never tracked: constant zero, no counter.
  assign pend[0]  = 2'd0;
  assign err_v[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_sb
    pend_cnt u_pend (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_inc  (issue && i_id_RegWrite && (i_id_rd == 5'(r))),
      .i_dec  (i_wb_valid && (i_wb_rd == 5'(r))),
      .o_cnt  (pend[r]),
      .o_err  (err_v[r])
    );
  end

  // Registered scoreboard only: a WB in this cycle does not unblock ID
  // until the next cycle.
  assign hazard = (i_id_uses_rs1 && (pend[i_id_rs1] != 2'd0)) ||
                  (i_id_uses_rs2 && (pend[i_id_rs2] != 2'd0));

  assign flush_now = i_ex_branch_taken || (state_q == FLUSH);
  assign stall_now = !flush_now && i_id_valid && hazard;
  assign issue     = i_rst_n && i_id_valid && !stall_now && !flush_now;

  // Outputs are forced to the "hold" pattern while reset is asserted.
  assign o_pc_en       = i_rst_n && !stall_now;
  assign o_ifid_en     = o_pc_en;
  assign o_ifid_flush  = i_rst_n && flush_now;
  assign o_idex_bubble = !i_rst_n || stall_now || flush_now;
  assign o_issue       = issue;
  assign o_stall_count = scnt_q;
  assign o_err         = err_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (i_ex_branch_taken) begin
      // Branch wins everywhere; with no extra cycles the resolution
      // cycle alone is the whole flush.
      if (FE != 3'd0) begin
        state_d = FLUSH;
        fcnt_d  = FE;
      end else begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    end else begin
      case (state_q)
        RUN:     if (stall_now) state_d = STALL;
        STALL:   if (!stall_now) state_d = RUN;
        FLUSH: begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_now && (scnt_q != '1)) scnt_q <= scnt_q + 1'b1;
      if (|err_v) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, u1, u2, rw, br, wbv;
  logic [4:0] rs1, rs2, rd, wbrd;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, issue, err;
  logic [3:0] stall_count;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_EXTRA(2), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_id_rd(rd), .i_id_RegWrite(rw), .i_ex_branch_taken(br),
    .i_wb_valid(wbv), .i_wb_rd(wbrd),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_issue(issue),
    .o_stall_count(stall_count), .o_err(err)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic rw;
    logic       br;  logic wbv; logic [4:0] wbrd;
    logic       pc, fl, bub, iss;
    logic [3:0] cnt;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
    input logic ub, input logic [4:0] d, input logic w, input logic bt,
    input logic wv, input logic [4:0] wr, input logic pc, input logic fl,
    input logic bub, input logic iss, input logic [3:0] cnt, input logic e);
    vec_t t;
    t.v = v; t.rs1 = a; t.u1 = ua; t.rs2 = b; t.u2 = ub; t.rd = d; t.rw = w;
    t.br = bt; t.wbv = wv; t.wbrd = wr; t.pc = pc; t.fl = fl; t.bub = bub;
    t.iss = iss; t.cnt = cnt; t.err = e;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic pc, input logic fl,
                         input logic bub, input logic iss, input int cnt,
                         input logic e);
    chk({tag, " pc_en"},   int'(pc_en), int'(pc));
    chk({tag, " ifid_en"}, int'(ifid_en), int'(pc));
    chk({tag, " flush"},   int'(ifid_flush), int'(fl));
    chk({tag, " bubble"},  int'(idex_bubble), int'(bub));
    chk({tag, " issue"},   int'(issue), int'(iss));
    chk({tag, " count"},   int'(stall_count), cnt);
    chk({tag, " err"},     int'(err), int'(e));
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; rs1 = t.rs1; u1 = t.u1; rs2 = t.rs2; u2 = t.u2;
    rd = t.rd; rw = t.rw; br = t.br; wbv = t.wbv; wbrd = t.wbrd;
  endtask

  initial begin
    // v, rs1,u1, rs2,u2, rd,rw, br, wbv,wbrd | pc,fl,bub,iss, cnt, err
    tbl.push_back(mk(1, 1,1, 2,1, 5,1, 0, 0,0,  1,0,0,1, 0, 0)); // 0 add x5
    tbl.push_back(mk(1, 5,1, 0,1, 6,1, 0, 0,0,  0,0,1,0, 0, 0)); // 1 RAW stall
    tbl.push_back(mk(1, 5,1, 0,1, 6,1, 0, 0,0,  0,0,1,0, 1, 0)); // 2
    tbl.push_back(mk(1, 5,1, 0,1, 6,1, 0, 1,5,  0,0,1,0, 2, 0)); // 3 WB x5
    tbl.push_back(mk(1, 5,1, 0,1, 6,1, 0, 0,0,  1,0,0,1, 3, 0)); // 4 issue
    tbl.push_back(mk(1, 0,1, 0,0, 0,1, 0, 0,0,  1,0,0,1, 3, 0)); // 5 write x0
    tbl.push_back(mk(1, 0,1, 0,1, 0,0, 0, 0,0,  1,0,0,1, 3, 0)); // 6 read x0
    tbl.push_back(mk(1, 1,1, 6,0, 0,0, 0, 0,0,  1,0,0,1, 3, 0)); // 7 unused rs2
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0,0,  0,0,1,0, 3, 0)); // 8 stall
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 1, 0,0,  1,1,1,0, 4, 0)); // 9 branch
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0,0,  1,1,1,0, 4, 0)); // 10 extra 1
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0,0,  1,1,1,0, 4, 0)); // 11 extra 2
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0,0,  0,0,1,0, 4, 0)); // 12 stall again
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 1,6,  0,0,1,0, 5, 0)); // 13 WB x6
    tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0,0,  1,0,0,1, 6, 0)); // 14 issue
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 0,0,  1,0,0,1, 6, 0)); // 15 pend7=1
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 1,7,  1,0,0,1, 6, 0)); // 16 same edge
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 0,0,  1,0,0,1, 6, 0)); // 17 pend7=2
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 0,0,  1,0,0,1, 6, 0)); // 18 pend7=3
    tbl.push_back(mk(1, 0,0, 0,0, 7,1, 0, 0,0,  1,0,0,1, 6, 0)); // 19 overflow
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0,0,  1,0,0,0, 6, 1)); // 20 err set
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 1,7,  1,0,0,0, 6, 1)); // 21 ->2
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 1,7,  1,0,0,0, 6, 1)); // 22 ->1
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0, 1,7,  0,0,1,0, 6, 1)); // 23 still 1
    tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0, 0,0,  1,0,0,1, 7, 1)); // 24 clear
    tbl.push_back(mk(1, 0,0, 0,0, 8,1, 0, 0,0,  1,0,0,1, 7, 1)); // 25 pend8=1

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {id_valid, u1, u2, rw, br, wbv} = 6'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      rd  = 5'($urandom); wbrd = 5'($urandom);
      @(negedge clk);
      chk_out($sformatf("reset%0d", i), 0, 0, 1, 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fl, tbl[i].bub,
              tbl[i].iss, int'(tbl[i].cnt), tbl[i].err);
      @(posedge clk); #1;
    end

    // Saturation: hold a hazard on x8 for 20 cycles, count starts at 7.
    drive(mk(1, 8,1, 0,0, 0,0, 0, 0,0, 0,0,0,0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d count", i), int'(stall_count),
          (7 + i > 15) ? 15 : 7 + i);
      chk($sformatf("sat%0d pc_en", i), int'(pc_en), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("sat final", int'(stall_count), 15);

    // Asynchronous reset mid-stall clears everything, including pend[8].
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("postrst", 1, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
